// File: rtl/clock_ui_pkg.sv
// Shared UI definitions for the clock's button handling and time-setting controller.
// Holds the button FSM state encoding and the default timing constants.
package clock_ui_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } ui_state_e;

  localparam int unsigned CLK_HZ        = 50_000_000;
  localparam int unsigned MS_DIV        = CLK_HZ / 1000;
  localparam int unsigned DEF_LONG_MS   = 1000;
  localparam int unsigned DEF_REPEAT_MS = 200;

  // Width needed to hold values up to and including n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..DIV-1 while enabled and flags the wrap cycle.
// Synchronous clear takes priority over enable.
module ms_tick_gen #(
  parameter int unsigned DIV = 50_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i & ~clr_i & (cnt_q == LAST);

endmodule

// File: rtl/button_event_fsm.sv
// Turns a debounced button level into press / short / long / auto-repeat pulses
// plus a held level; all outputs are registered.
module button_event_fsm
  import clock_ui_pkg::*;
#(
  parameter int unsigned TICK_DIV  = MS_DIV,
  parameter int unsigned LONG_MS   = DEF_LONG_MS,
  parameter int unsigned REPEAT_MS = DEF_REPEAT_MS
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic rpt_pulse,
  output logic held
);

  localparam int unsigned MS_W  = cnt_width(LONG_MS);
  localparam int unsigned RPT_W = cnt_width(REPEAT_MS);
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(LONG_MS - 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_MS - 1);

  ui_state_e        state_q, state_d;
  logic             btn_q;
  logic             arm_q;
  logic [MS_W-1:0]  ms_cnt_q, ms_cnt_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             press_q, press_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             rpt_q, rpt_d;
  logic             held_q, held_d;

  logic rise;
  logic fall;
  logic tick;

  // arm_q blocks a rise on the first edge after reset, so a button already
  // held through reset must be released and pressed again.
  assign rise = btn & ~btn_q & arm_q;
  assign fall = ~btn & btn_q;

  ms_tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (rise),
    .en_i   (state_q != ST_IDLE),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    ms_cnt_d  = ms_cnt_q;
    rpt_cnt_d = rpt_cnt_q;
    press_d   = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    rpt_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          press_d  = 1'b1;
          ms_cnt_d = '0;
          state_d  = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        if (fall) begin
          short_d = 1'b1;
          state_d = ST_IDLE;
        end else if (tick) begin
          if (ms_cnt_q == MS_LAST) begin
            long_d    = 1'b1;
            rpt_cnt_d = '0;
            state_d   = ST_HELD;
          end else begin
            ms_cnt_d = ms_cnt_q + 1'b1;
          end
        end
      end
      ST_HELD: begin
        if (fall) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (rpt_cnt_q == RPT_LAST) begin
            rpt_d     = 1'b1;
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    held_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      btn_q     <= '0;
      arm_q     <= '0;
      ms_cnt_q  <= '0;
      rpt_cnt_q <= '0;
      press_q   <= '0;
      short_q   <= '0;
      long_q    <= '0;
      rpt_q     <= '0;
      held_q    <= '0;
    end else begin
      state_q   <= state_d;
      btn_q     <= btn;
      arm_q     <= 1'b1;
      ms_cnt_q  <= ms_cnt_d;
      rpt_cnt_q <= rpt_cnt_d;
      press_q   <= press_d;
      short_q   <= short_d;
      long_q    <= long_d;
      rpt_q     <= rpt_d;
      held_q    <= held_d;
    end
  end

  assign press_pulse = press_q;
  assign short_pulse = short_q;
  assign long_pulse  = long_q;
  assign rpt_pulse   = rpt_q;
  assign held        = held_q;

endmodule

// File: tb/tb_button_event_fsm.sv
// Bench for button_event_fsm: directed scenarios plus random button traffic,
// checked every cycle against an elapsed-time model of the press events.
module tb_button_event_fsm;

  localparam int TD = 4;
  localparam int LM = 5;
  localparam int RM = 2;
  localparam int LD = LM * TD;
  localparam int RD = RM * TD;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic btn   = 1'b0;
  logic press_pulse, short_pulse, long_pulse, rpt_pulse, held;
  logic [4:0] outs;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  bit         m_in;
  bit         m_prev;
  bit         m_armed;
  int         m_p;
  logic [4:0] exp_v;

  button_event_fsm #(
    .TICK_DIV  (TD),
    .LONG_MS   (LM),
    .REPEAT_MS (RM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn         (btn),
    .press_pulse (press_pulse),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .rpt_pulse   (rpt_pulse),
    .held        (held)
  );

  always #5 clk = ~clk;

  assign outs = {press_pulse, short_pulse, long_pulse, rpt_pulse, held};

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
    end
  endtask

  // Events derived from time since the press was reported (cycle m_p).
  task automatic model_edge(input logic b);
    logic pr, sh, lg, rp, hd;
    int e;
    pr = 1'b0; sh = 1'b0; lg = 1'b0; rp = 1'b0; hd = 1'b0;
    if (!reset) begin
      m_in = 0; m_prev = 0; m_armed = 0;
    end else begin
      if (m_in) begin
        if (!b) begin
          sh   = (cyc <= m_p + LD);
          m_in = 0;
        end else begin
          e  = cyc - m_p;
          lg = (e == LD);
          rp = (e > LD) && ((e - LD) % RD == 0);
          hd = 1'b1;
        end
      end else if (b && !m_prev && m_armed) begin
        pr   = 1'b1;
        hd   = 1'b1;
        m_p  = cyc;
        m_in = 1;
      end
      m_prev  = b;
      m_armed = 1;
    end
    exp_v = {pr, sh, lg, rp, hd};
  endtask

  task automatic step(input logic b);
    btn = b;
    @(posedge clk);
    cyc++;
    model_edge(b);
    #1;
    check("outputs", outs, exp_v);
    check("onehot_pulses", {4'b0, $onehot0(outs[4:1])}, 5'b00001);
  endtask

  task automatic run_until(input int last, input logic b);
    while (cyc < last) step(b);
  endtask

  task automatic async_reset();
    reset = 1'b0;
    m_in = 0; m_prev = 0; m_armed = 0;
    #1;
    check("reset_outputs_zero", outs, 5'b00000);
  endtask

  task automatic do_reset();
    btn = 1'b0;
    async_reset();
    repeat (2) step(1'b0);
    reset = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int len;
    logic b;
    #2;

    // Short press
    do_reset();
    run_until(10, 1'b0);
    run_until(11, 1'b1);
    check("short:press@11", {4'b0, press_pulse}, 5'd1);
    run_until(25, 1'b1);
    check("short:held@25", {4'b0, held}, 5'd1);
    run_until(26, 1'b0);
    check("short:short@26", {4'b0, short_pulse}, 5'd1);
    check("short:held_low@26", {4'b0, held}, 5'd0);
    run_until(40, 1'b0);

    // Long hold with repeats
    do_reset();
    run_until(10, 1'b0);
    run_until(31, 1'b1);
    check("long:long@31", {4'b0, long_pulse}, 5'd1);
    run_until(39, 1'b1);
    check("long:rpt@39", {4'b0, rpt_pulse}, 5'd1);
    run_until(47, 1'b1);
    check("long:rpt@47", {4'b0, rpt_pulse}, 5'd1);
    run_until(55, 1'b1);
    check("long:rpt@55", {4'b0, rpt_pulse}, 5'd1);
    run_until(60, 1'b1);
    run_until(61, 1'b0);
    check("long:release@61", {3'b0, short_pulse, held}, 5'd0);
    run_until(70, 1'b0);

    // Fall on the long-threshold tick
    do_reset();
    run_until(10, 1'b0);
    run_until(30, 1'b1);
    run_until(31, 1'b0);
    check("race:short@31", {4'b0, short_pulse}, 5'd1);
    check("race:no_long@31", {4'b0, long_pulse}, 5'd0);
    run_until(40, 1'b0);

    // Reset during HELD, button still down at release
    do_reset();
    run_until(10, 1'b0);
    run_until(35, 1'b1);
    async_reset();
    run_until(40, 1'b1);
    reset = 1'b1;
    run_until(45, 1'b1);
    check("rst:no_events_after_release", outs, 5'd0);
    run_until(50, 1'b0);
    run_until(51, 1'b1);
    check("rst:press@51", {4'b0, press_pulse}, 5'd1);
    run_until(60, 1'b0);

    // Back-to-back presses
    do_reset();
    run_until(10, 1'b0);
    run_until(11, 1'b1);
    check("b2b:press@11", {4'b0, press_pulse}, 5'd1);
    run_until(13, 1'b1);
    run_until(14, 1'b0);
    check("b2b:short@14", {4'b0, short_pulse}, 5'd1);
    run_until(15, 1'b0);
    run_until(16, 1'b1);
    check("b2b:press@16", {4'b0, press_pulse}, 5'd1);
    run_until(18, 1'b1);
    run_until(19, 1'b0);
    check("b2b:short@19", {4'b0, short_pulse}, 5'd1);
    run_until(30, 1'b0);

    // Random button traffic with occasional asynchronous resets
    do_reset();
    b = 1'b0;
    for (int r = 0; r < 200; r++) begin
      b   = ~b;
      len = (r % 3 == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 60));
      for (int i = 0; i < len; i++) step(b);
      if ($urandom_range(0, 14) == 0) begin
        async_reset();
        repeat ($urandom_range(1, 3)) step(1'($urandom_range(0, 1)));
        reset = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
